// File: rtl/game_pkg.sv
// Shared constants for the match sequencer: state codes, winner codes,
// parameter defaults and the range clamps applied to them.
package game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SERVE = 3'd1;
    localparam state_t ST_RALLY = 3'd2;
    localparam state_t ST_POINT = 3'd3;
    localparam state_t ST_PAUSE = 3'd4;
    localparam state_t ST_OVER  = 3'd5;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam int DEF_WIN_SCORE    = 7;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_POINT_FRAMES = 90;

    // Out-of-range parameters are pulled to the nearest legal value.
    function automatic logic [3:0] clamp_win(input int v);
        logic [31:0] w_v;
        w_v = v;
        if (v < 1)  return 4'd1;
        if (v > 15) return 4'd15;
        return w_v[3:0];
    endfunction

    function automatic logic [7:0] clamp_frames(input int v);
        logic [31:0] w_v;
        w_v = v;
        if (v < 1)   return 8'd1;
        if (v > 255) return 8'd255;
        return w_v[7:0];
    endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Frame/button/score inputs and sequencer outputs of match_ctrl.
interface match_ctrl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       pause_btn;
    logic       point_pulse;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       phys_step;
    logic       phys_rst_n;
    logic [2:0] state;
    logic       serve_side;
    logic [7:0] timer;
    logic [1:0] winner;
    logic       match_over;

    modport master (
        output frame_tick, start_btn, pause_btn, point_pulse, p1_score, p2_score,
        input  phys_step, phys_rst_n, state, serve_side, timer, winner, match_over
    );

    modport slave (
        input  frame_tick, start_btn, pause_btn, point_pulse, p1_score, p2_score,
        output phys_step, phys_rst_n, state, serve_side, timer, winner, match_over
    );
endinterface

// File: rtl/edge_rise.sv
// Registered rising-edge detector for a synchronous, debounced level.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_rise
);
    logic r_lvl_d;
    logic r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_lvl_d <= i_lvl;
            r_rise  <= i_lvl & ~r_lvl_d;
        end
    end

    assign o_rise = r_rise;
endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: serve countdown, rally stepping, point display, pause, game over.
//
// state | meaning
// IDLE  | waiting for start; physics held as-is
// SERVE | frozen serve countdown on frame ticks
// RALLY | physics stepped once per frame tick
// POINT | score display countdown after a point
// PAUSE | frozen; remembers SERVE or RALLY to resume
// OVER  | match finished, winner shown until start
module match_ctrl
    import game_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
    input logic         clk,
    input logic         rst_n,
    match_ctrl_if.slave bus
);
    localparam logic [3:0] WIN_C   = clamp_win(WIN_SCORE);
    localparam logic [7:0] SERVE_C = clamp_frames(SERVE_FRAMES);
    localparam logic [7:0] POINT_C = clamp_frames(POINT_FRAMES);

    logic w_start_rise;
    logic w_pause_rise;
    logic [7:0] w_timer_dec;
    logic w_timer_last;
    logic w_someone_won;

    state_t     r_state;
    state_t     r_ret;
    logic [7:0] r_timer;
    logic       r_serve_side;
    logic [1:0] r_winner;
    logic       r_match_over;
    logic       r_phys_step;
    logic       r_phys_rst_n;
    logic [3:0] r_prev_p1;
    logic [3:0] r_prev_p2;

    edge_rise u_start_edge (.clk(clk), .rst_n(rst_n), .i_lvl(bus.start_btn), .o_rise(w_start_rise));
    edge_rise u_pause_edge (.clk(clk), .rst_n(rst_n), .i_lvl(bus.pause_btn), .o_rise(w_pause_rise));

    assign w_timer_dec   = (r_timer == 8'd0) ? 8'd0 : r_timer - 8'd1;
    assign w_timer_last  = (r_timer <= 8'd1);
    assign w_someone_won = (bus.p1_score >= WIN_C) || (bus.p2_score >= WIN_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ret        <= ST_IDLE;
            r_timer      <= 8'd0;
            r_serve_side <= 1'b0;
            r_winner     <= WIN_NONE;
            r_match_over <= 1'b0;
            r_phys_step  <= 1'b0;
            r_phys_rst_n <= 1'b0;
            r_prev_p1    <= 4'd0;
            r_prev_p2    <= 4'd0;
        end else begin
            r_phys_step  <= 1'b0;
            r_phys_rst_n <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        // Physics scores are being cleared this cycle, so the baseline is zero.
                        r_phys_rst_n <= 1'b0;
                        r_timer      <= SERVE_C;
                        r_serve_side <= 1'b0;
                        r_prev_p1    <= 4'd0;
                        r_prev_p2    <= 4'd0;
                        r_state      <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (w_pause_rise) begin
                        r_ret   <= ST_SERVE;
                        r_state <= ST_PAUSE;
                    end else if (bus.frame_tick) begin
                        r_timer <= w_timer_dec;
                        if (w_timer_last) r_state <= ST_RALLY;
                    end
                end
                ST_RALLY: begin
                    if (bus.point_pulse) begin
                        r_serve_side <= (bus.p2_score > r_prev_p2);
                        r_timer      <= POINT_C;
                        r_state      <= ST_POINT;
                    end else if (w_pause_rise) begin
                        r_ret   <= ST_RALLY;
                        r_state <= ST_PAUSE;
                    end else if (bus.frame_tick) begin
                        r_phys_step <= 1'b1;
                    end
                end
                ST_POINT: begin
                    if (bus.frame_tick) begin
                        if (!w_timer_last) begin
                            r_timer <= w_timer_dec;
                        end else if (w_someone_won) begin
                            r_timer      <= 8'd0;
                            r_winner     <= (bus.p1_score >= WIN_C) ? WIN_P1 : WIN_P2;
                            r_match_over <= 1'b1;
                            r_state      <= ST_OVER;
                        end else begin
                            r_timer   <= SERVE_C;
                            r_prev_p1 <= bus.p1_score;
                            r_prev_p2 <= bus.p2_score;
                            r_state   <= ST_SERVE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_rise) r_state <= r_ret;
                end
                ST_OVER: begin
                    if (w_start_rise) begin
                        r_winner     <= WIN_NONE;
                        r_match_over <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.phys_step  = r_phys_step;
    assign bus.phys_rst_n = r_phys_rst_n;
    assign bus.state      = r_state;
    assign bus.serve_side = r_serve_side;
    assign bus.timer      = r_timer;
    assign bus.winner     = r_winner;
    assign bus.match_over = r_match_over;
endmodule

// File: tb/tb_match_ctrl.sv
// Scenario bench for match_ctrl: expectations queued as stimulus is applied,
// then popped and compared against the sampled outputs.
module tb_match_ctrl;
    import game_pkg::*;

    localparam int SEL_STATE = 0;
    localparam int SEL_TIMER = 1;
    localparam int SEL_SERVE = 2;
    localparam int SEL_WIN   = 3;
    localparam int SEL_OVER  = 4;
    localparam int SEL_STEP  = 5;
    localparam int SEL_PRST  = 6;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t sb[$];

    match_ctrl_if bus ();

    match_ctrl #(.WIN_SCORE(7), .SERVE_FRAMES(60), .POINT_FRAMES(90)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int sample(input int sel);
        case (sel)
            SEL_STATE: return int'(bus.state);
            SEL_TIMER: return int'(bus.timer);
            SEL_SERVE: return int'(bus.serve_side);
            SEL_WIN:   return int'(bus.winner);
            SEL_OVER:  return int'(bus.match_over);
            SEL_STEP:  return int'(bus.phys_step);
            default:   return int'(bus.phys_rst_n);
        endcase
    endfunction

    function automatic void expect_sig(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endfunction

    task automatic sb_drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, sample(e.sel), e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        cyc();
        bus.start_btn = 1'b0;
        cyc();
    endtask

    task automatic press_pause();
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn = 1'b0;
        cyc();
    endtask

    // Each tick is a one-clk pulse followed by an idle clk; counts phys_step highs seen.
    task automatic ticks(input int n, output int steps);
        steps = 0;
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cyc();
            bus.frame_tick = 1'b0;
            if (bus.phys_step) steps++;
            cyc();
            if (bus.phys_step) steps++;
        end
    endtask

    task automatic start_to_rally(input string pfx);
        int s;
        press_start();
        expect_sig({pfx, "_prst_low"}, SEL_PRST, 0);
        expect_sig({pfx, "_serve_state"}, SEL_STATE, ST_SERVE);
        expect_sig({pfx, "_serve_timer"}, SEL_TIMER, 60);
        expect_sig({pfx, "_serve_side"}, SEL_SERVE, 0);
        sb_drain();
        cyc();
        expect_sig({pfx, "_prst_release"}, SEL_PRST, 1);
        sb_drain();
        ticks(59, s);
        expect_sig({pfx, "_t59_state"}, SEL_STATE, ST_SERVE);
        expect_sig({pfx, "_t59_timer"}, SEL_TIMER, 1);
        sb_drain();
        chk({pfx, "_serve_no_step"}, s, 0);
        ticks(1, s);
        expect_sig({pfx, "_rally_state"}, SEL_STATE, ST_RALLY);
        expect_sig({pfx, "_rally_timer"}, SEL_TIMER, 0);
        sb_drain();
        chk({pfx, "_t60_no_step"}, s, 0);
        ticks(5, s);
        chk({pfx, "_rally_steps"}, s, 5);
    endtask

    initial begin
        int s;
        bus.frame_tick  = 1'b0;
        bus.start_btn   = 1'b0;
        bus.pause_btn   = 1'b0;
        bus.point_pulse = 1'b0;
        bus.p1_score    = 4'd0;
        bus.p2_score    = 4'd0;

        // Reset values
        repeat (3) cyc();
        expect_sig("rst_state", SEL_STATE, ST_IDLE);
        expect_sig("rst_timer", SEL_TIMER, 0);
        expect_sig("rst_serve", SEL_SERVE, 0);
        expect_sig("rst_winner", SEL_WIN, WIN_NONE);
        expect_sig("rst_over", SEL_OVER, 0);
        expect_sig("rst_step", SEL_STEP, 0);
        expect_sig("rst_prst", SEL_PRST, 0);
        sb_drain();
        rst_n = 1'b1;
        cyc();
        expect_sig("rst_prst_release", SEL_PRST, 1);
        expect_sig("idle_hold", SEL_STATE, ST_IDLE);
        sb_drain();

        start_to_rally("a");

        // Pause in RALLY freezes stepping
        press_pause();
        expect_sig("pause_rally_state", SEL_STATE, ST_PAUSE);
        sb_drain();
        ticks(10, s);
        chk("pause_no_step", s, 0);
        expect_sig("pause_hold_state", SEL_STATE, ST_PAUSE);
        sb_drain();
        press_pause();
        expect_sig("resume_rally", SEL_STATE, ST_RALLY);
        sb_drain();
        ticks(2, s);
        chk("resume_steps", s, 2);

        // Point by P2
        bus.p2_score    = 4'd1;
        bus.point_pulse = 1'b1;
        cyc();
        bus.point_pulse = 1'b0;
        expect_sig("point_state", SEL_STATE, ST_POINT);
        expect_sig("point_timer", SEL_TIMER, 90);
        expect_sig("point_serve_p2", SEL_SERVE, 1);
        expect_sig("point_step0", SEL_STEP, 0);
        sb_drain();
        bus.point_pulse = 1'b1;
        cyc();
        bus.point_pulse = 1'b0;
        press_pause();
        expect_sig("point_ignore_pp_pause", SEL_STATE, ST_POINT);
        expect_sig("point_ignore_timer", SEL_TIMER, 90);
        sb_drain();
        ticks(89, s);
        expect_sig("point_t89_timer", SEL_TIMER, 1);
        expect_sig("point_t89_state", SEL_STATE, ST_POINT);
        sb_drain();
        chk("point_no_step", s, 0);
        ticks(1, s);
        expect_sig("point_exp_state", SEL_STATE, ST_SERVE);
        expect_sig("point_exp_timer", SEL_TIMER, 60);
        sb_drain();

        // Pause in SERVE at timer 30, with a tick on the pausing clk
        ticks(30, s);
        expect_sig("serve_t30", SEL_TIMER, 30);
        sb_drain();
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn  = 1'b0;
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        expect_sig("serve_pause_state", SEL_STATE, ST_PAUSE);
        expect_sig("serve_pause_timer", SEL_TIMER, 30);
        sb_drain();
        ticks(5, s);
        expect_sig("serve_pause_frozen", SEL_TIMER, 30);
        sb_drain();
        press_pause();
        expect_sig("serve_resume_state", SEL_STATE, ST_SERVE);
        expect_sig("serve_resume_timer", SEL_TIMER, 30);
        sb_drain();
        ticks(30, s);
        expect_sig("rally2_state", SEL_STATE, ST_RALLY);
        sb_drain();

        // Point and pause edge on the same clk: point wins, scorer is P1
        bus.pause_btn = 1'b1;
        cyc();
        bus.pause_btn   = 1'b0;
        bus.point_pulse = 1'b1;
        bus.p1_score    = 4'd1;
        cyc();
        bus.point_pulse = 1'b0;
        expect_sig("simul_state", SEL_STATE, ST_POINT);
        expect_sig("simul_serve_p1", SEL_SERVE, 0);
        expect_sig("simul_timer", SEL_TIMER, 90);
        sb_drain();
        repeat (3) cyc();
        expect_sig("simul_no_pause", SEL_STATE, ST_POINT);
        sb_drain();

        // P1 reaches WIN_SCORE during POINT
        bus.p1_score = 4'd7;
        ticks(90, s);
        expect_sig("over_state", SEL_STATE, ST_OVER);
        expect_sig("over_winner", SEL_WIN, WIN_P1);
        expect_sig("over_flag", SEL_OVER, 1);
        sb_drain();
        press_pause();
        expect_sig("over_ignore_pause", SEL_STATE, ST_OVER);
        sb_drain();
        bus.start_btn = 1'b1;
        repeat (5) cyc();
        bus.start_btn = 1'b0;
        cyc();
        expect_sig("over_to_idle", SEL_STATE, ST_IDLE);
        expect_sig("over_winner_clr", SEL_WIN, WIN_NONE);
        expect_sig("over_flag_clr", SEL_OVER, 0);
        sb_drain();

        // Reset mid-PAUSE
        bus.p1_score = 4'd0;
        bus.p2_score = 4'd0;
        start_to_rally("b");
        press_pause();
        expect_sig("b_pause_state", SEL_STATE, ST_PAUSE);
        sb_drain();
        rst_n = 1'b0;
        #1;
        expect_sig("async_rst_state", SEL_STATE, ST_IDLE);
        expect_sig("async_rst_prst", SEL_PRST, 0);
        expect_sig("async_rst_timer", SEL_TIMER, 0);
        sb_drain();
        cyc();
        rst_n = 1'b1;
        cyc();
        press_pause();
        expect_sig("post_rst_pause_ignored", SEL_STATE, ST_IDLE);
        sb_drain();
        start_to_rally("c");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIN_SCORE, 7: points that end the match.
- SERVE_FRAMES, 60: frames frozen before each serve.
- POINT_FRAMES, 90: frames the score is displayed after a point.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst_n, in, 1: async active-low reset.
- frame_tick, in, 1: one-clk pulse per video frame.
- start_btn, in, 1: debounced level.
- pause_btn, in, 1: debounced level.
- point_pulse, in, 1: one-clk point-scored pulse from the physics block.
- p1_score, in, 4: physics score.
- p2_score, in, 4: physics score.
- phys_step, out, 1: physics clock-enable pulse.
- phys_rst_n, out, 1: active-low physics/score clear.
- state, out, 3: FSM state code.
- serve_side, out, 1: 0 = P1, 1 = P2.
- timer, out, 8: frames remaining in SERVE/POINT.
- winner, out, 2: 0 = none, 1 = P1, 2 = P2.
- match_over, out, 1: high in OVER.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 FSM states SHALL be IDLE=0, SERVE=1, RALLY=2, POINT=3, PAUSE=4, OVER=5; codes 6 and 7 SHALL go to IDLE next cycle.
REQ-005 start_btn and pause_btn SHALL be rising-edge detected internally; a level held high SHALL act only once.
REQ-006 IDLE: a start edge SHALL drive phys_rst_n low for exactly 1 clk, load timer=SERVE_FRAMES, set serve_side=0 and go to SERVE.
REQ-007 SERVE: timer SHALL decrement on each frame_tick; on the tick where timer==1 it SHALL become 0 and the FSM SHALL enter RALLY.
REQ-008 RALLY: phys_step SHALL be a registered 1-clk pulse in the clk after each frame_tick; phys_step SHALL be 0 in every other state.
REQ-009 RALLY: point_pulse SHALL go to POINT and load timer=POINT_FRAMES.
REQ-010 On point_pulse, serve_side SHALL be set to the scorer: 1 if p2_score > prev_p2, else 0. prev_p1 and prev_p2 are registered copies of the scores taken on entry to SERVE.
REQ-011 POINT: timer SHALL count down as in REQ-007; at 0 the FSM SHALL go to OVER if p1_score>=WIN_SCORE or p2_score>=WIN_SCORE, else load SERVE_FRAMES and go to SERVE.
REQ-012 OVER: winner SHALL be 1 if p1_score>=WIN_SCORE, else 2.
REQ-013 OVER: match_over SHALL be 1; a start edge SHALL clear winner and go to IDLE.
REQ-014 A pause edge in SERVE or RALLY SHALL enter PAUSE and store the return state; a pause edge in PAUSE SHALL resume the stored state.
REQ-015 PAUSE SHALL freeze timer, with phys_step=0.
REQ-016 Pause edges SHALL be ignored in IDLE, POINT and OVER.
REQ-017 Simultaneous events SHALL be prioritised point_pulse > pause edge > timer expiry.
REQ-018 A point_pulse outside RALLY SHALL be ignored.
REQ-019 A frame_tick in the cycle that pauses SHALL NOT decrement timer.
REQ-020 timer SHALL saturate at 0 and never wrap.
REQ-021 Score comparisons SHALL be unsigned 4-bit.
REQ-022 WIN_SCORE SHALL be limited to 1..15; SERVE_FRAMES and POINT_FRAMES SHALL be limited to 1..255.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 On rst_n low, the block SHALL asynchronously set state=IDLE, timer=0, serve_side=0, winner=0, match_over=0, phys_step=0, prev scores=0 and edge-detect registers=0.
REQ-025 phys_rst_n SHALL be driven 0 while rst_n is low and release to 1 on the first clk after deassertion.
REQ-026 Reset mid-rally or mid-pause SHALL discard the stored return state.

Structure
REQ-027 State codes, winner codes and parameter defaults SHALL live in the shared package game_pkg.
REQ-028 A sub-module edge_rise (registered rising-edge detector, clk/rst_n) SHALL be instantiated twice.
REQ-029 The FSM, timer and phys_step generation SHALL reside in match_ctrl.

Verification
REQ-030 Reset, then a start edge with 60 frame_ticks: phys_rst_n is low 1 clk, state goes 1 then 2 after tick 60, and phys_step pulses once per tick from then on.
REQ-031 In RALLY, point_pulse with p2_score 0 to 1: state=3, timer=90, serve_side=1; after 90 ticks, state=1 and timer=60.
REQ-032 p1_score=7 at POINT expiry: state=5, winner=1, match_over=1; a start edge then gives state=0 and winner=0.
REQ-033 Pause edge in RALLY: state=4 and no phys_step for 10 ticks; a second edge resumes state=2. Pause in SERVE at timer=30 holds timer=30.
REQ-034 point_pulse and a pause edge in the same clk: state=3, with no PAUSE entered.
REQ-035 rst_n asserted mid-PAUSE: state=0 immediately, and a subsequent start behaves as REQ-030.
